// File: rtl/fdtd_boundary_pe_param_if.sv
// Purpose: bundles the host-load, neighbour-read, Vn+1 capture and status signals of one boundary PE.
// Latency: n/a (wiring only); master = mesh/host side, slave = the PE.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
interface fdtd_boundary_pe_param_if #(
    parameter int DATA_W  = 27,
    parameter int ADDR_W  = 7,
    parameter int PE_ID_W = 6,
    parameter int CNT_W   = 8
);
    logic [PE_ID_W-1:0] pe_number;       // this PE's index, static
    logic [PE_ID_W-1:0] target_pe;       // host load target
    logic [DATA_W-1:0]  data;            // host load data
    logic [ADDR_W-1:0]  addr;            // host load / readback address
    logic               we;              // host write strobe
    logic               computing_on;    // 1 = FDTD run, 0 = host access
    logic [1:0]         mode;            // boundary mode
    logic [ADDR_W-1:0]  n_addr;          // neighbour read address
    logic               n_valid;
    logic [DATA_W-1:0]  out_n;           // registered read data
    logic               out_valid;
    logic [DATA_W-1:0]  Vn1;             // next-step voltage
    logic [ADDR_W-1:0]  Vn1_addr;
    logic               Vn1_valid;
    logic               starting_write;  // write phase of the step open
    logic               finishing_fdtd;  // run ending
    logic               busy;
    logic [CNT_W-1:0]   boundary_cnt;

    modport master (
        output pe_number, target_pe, data, addr, we, computing_on, mode,
               n_addr, n_valid, Vn1, Vn1_addr, Vn1_valid, starting_write, finishing_fdtd,
        input  out_n, out_valid, busy, boundary_cnt
    );

    modport slave (
        input  pe_number, target_pe, data, addr, we, computing_on, mode,
               n_addr, n_valid, Vn1, Vn1_addr, Vn1_valid, starting_write, finishing_fdtd,
        output out_n, out_valid, busy, boundary_cnt
    );
endinterface

// File: rtl/fdtd_boundary_pe_param.sv
// Purpose: boundary-condition PE; RAM of boundary voltages, host load in IDLE, neighbour reads and Vn+1 capture in RUN.
// Latency: reads/readback 1 cycle (registered out_n), write-first bypass on same-address capture.
// Backpressure: none; out_valid qualifies out_n. Ports: clk, rst (sync, active high), io (slave modport).
module fdtd_boundary_pe_param #(
    parameter int DATA_W      = 27,
    parameter int ADDR_W      = 7,
    parameter int PE_ID_W     = 6,
    parameter int READ_OFFSET = 2,
    parameter int LO_BOUND    = 4,
    parameter int HI_BOUND    = 105,
    parameter int EDGE_PE     = 0,
    parameter int DAMP_SHIFT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    fdtd_boundary_pe_param_if.slave  io
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  RD_OFS = ADDR_W'(READ_OFFSET);
    localparam logic [ADDR_W-1:0]  LO_A   = ADDR_W'(LO_BOUND);
    localparam logic [ADDR_W-1:0]  HI_A   = ADDR_W'(HI_BOUND);
    localparam logic [PE_ID_W-1:0] EDGE_A = PE_ID_W'(EDGE_PE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic                cnt_clr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_addr;
    logic                bound_node;
    logic                bw;
    logic                host_we;
    logic signed [DATA_W-1:0] vn1_s, damped, wdata;
    logic [DATA_W-1:0]   out_n_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    cnt_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Abort (computing_on low) takes priority over an orderly finish.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: if (io.computing_on) begin
                state_nxt = RUN;
                cnt_clr   = 1'b1;
            end
            RUN: begin
                if (!io.computing_on)       state_nxt = IDLE;
                else if (io.finishing_fdtd) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wrap-around comes for free from ADDR_W-bit modular subtraction.
    assign rd_addr    = io.n_addr - RD_OFS;
    assign bound_node = (io.pe_number == EDGE_A) || (io.Vn1_addr < LO_A) || (io.Vn1_addr > HI_A);
    assign bw         = (state == RUN) && io.starting_write && !io.finishing_fdtd && io.Vn1_valid
                        && ((io.mode == 2'd1) || (io.mode == 2'd2)) && bound_node;
    assign host_we    = (state == IDLE) && io.we && (io.target_pe == io.pe_number);

    assign vn1_s  = $signed(io.Vn1);
    assign damped = vn1_s - (vn1_s >>> DAMP_SHIFT);
    assign wdata  = (io.mode == 2'd2) ? damped : vn1_s;

    // Host and boundary writes live in disjoint states, so one write port suffices.
    always_ff @(posedge clk) begin
        if (host_we)  mem[io.addr]     <= io.data;
        else if (bw)  mem[io.Vn1_addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_n_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_n_q     <= mem[io.addr];
                    out_valid_q <= 1'b0;
                end
                RUN: begin
                    out_n_q     <= (bw && (io.Vn1_addr == rd_addr)) ? wdata : mem[rd_addr];
                    out_valid_q <= io.computing_on && io.n_valid;
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                cnt_q <= '0;
        else if (cnt_clr)       cnt_q <= '0;
        else if (bw && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end

    assign io.out_n        = out_n_q;
    assign io.out_valid    = out_valid_q;
    assign io.busy         = (state != IDLE);
    assign io.boundary_cnt = cnt_q;
endmodule

// File: tb/tb_fdtd_boundary_pe_param.sv
// Purpose: self-checking bench for fdtd_boundary_pe_param: directed scenarios plus randomized traffic against a reference model.
// Latency: model expects every read one cycle after it is presented.
// Backpressure: none; stimulus is applied each cycle at posedge+1, outputs sampled at the next posedge+1.
module tb_fdtd_boundary_pe_param;
    localparam int DATA_W      = 27;
    localparam int ADDR_W      = 7;
    localparam int PE_ID_W     = 6;
    localparam int READ_OFFSET = 2;
    localparam int LO_BOUND    = 4;
    localparam int HI_BOUND    = 105;
    localparam int EDGE_PE     = 0;
    localparam int DAMP_SHIFT  = 4;
    localparam int CNT_W       = 2;
    localparam int DEPTH       = 2 ** ADDR_W;
    localparam int CNT_MAX     = 2 ** CNT_W - 1;

    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fdtd_boundary_pe_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PE_ID_W(PE_ID_W), .CNT_W(CNT_W)) io ();

    fdtd_boundary_pe_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PE_ID_W(PE_ID_W), .READ_OFFSET(READ_OFFSET),
        .LO_BOUND(LO_BOUND), .HI_BOUND(HI_BOUND), .EDGE_PE(EDGE_PE),
        .DAMP_SHIFT(DAMP_SHIFT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(io)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                known   [DEPTH];
    int                ph      = P_IDLE;
    int                e_cnt   = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic bit is_bnd(input logic [PE_ID_W-1:0] pe, input logic [ADDR_W-1:0] a);
        return (int'(pe) == EDGE_PE) || (int'(a) < LO_BOUND) || (int'(a) > HI_BOUND);
    endfunction

    // v - floor(v / 2**DAMP_SHIFT), done with integer division.
    function automatic logic [DATA_W-1:0] damp(input logic [DATA_W-1:0] v);
        int s, d, q;
        s = int'($signed(v));
        d = 2 ** DAMP_SHIFT;
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        return DATA_W'(s - q);
    endfunction

    // Advance one clock: predict from the current inputs, then compare after the edge.
    task automatic tick();
        logic [DATA_W-1:0] e_n, wv;
        logic              e_v;
        int                rd;
        bit                bw, chk_n;
        e_n   = '0;
        e_v   = 1'b0;
        chk_n = 1'b0;
        if (rst) begin
            ph = P_IDLE; e_cnt = 0; chk_n = 1'b1;
        end else if (ph == P_IDLE) begin
            e_n   = ref_mem[io.addr];
            chk_n = known[io.addr];
            if (io.we && io.target_pe == io.pe_number) begin
                ref_mem[io.addr] = io.data;
                known[io.addr]   = 1'b1;
            end
            if (io.computing_on) begin ph = P_RUN; e_cnt = 0; end
        end else if (ph == P_RUN) begin
            rd = (int'(io.n_addr) + DEPTH - READ_OFFSET) % DEPTH;
            bw = io.starting_write && !io.finishing_fdtd && io.Vn1_valid
                 && (io.mode == 2'd1 || io.mode == 2'd2) && is_bnd(io.pe_number, io.Vn1_addr);
            wv = (io.mode == 2'd2) ? damp(io.Vn1) : io.Vn1;
            if (bw && int'(io.Vn1_addr) == rd) begin
                e_n = wv; chk_n = 1'b1;
            end else begin
                e_n = ref_mem[rd]; chk_n = known[rd];
            end
            if (bw) begin
                ref_mem[io.Vn1_addr] = wv;
                known[io.Vn1_addr]   = 1'b1;
                if (e_cnt < CNT_MAX) e_cnt++;
            end
            if (!io.computing_on) begin
                ph = P_IDLE; chk_n = 1'b0;
            end else begin
                e_v   = io.n_valid;
                chk_n = chk_n && io.n_valid;
                if (io.finishing_fdtd) ph = P_DRAIN;
            end
        end else begin
            ph = P_IDLE;
        end
        @(posedge clk);
        #1;
        chk("out_valid", DATA_W'(io.out_valid), DATA_W'(e_v));
        chk("busy", DATA_W'(io.busy), DATA_W'(ph != P_IDLE));
        chk("boundary_cnt", DATA_W'(io.boundary_cnt), DATA_W'(e_cnt));
        if (chk_n) chk("out_n", io.out_n, e_n);
    endtask

    task automatic run_start();
        io.computing_on = 1'b1;
        tick();
    endtask

    task automatic run_end();
        io.Vn1_valid = 1'b0; io.n_valid = 1'b0; io.finishing_fdtd = 1'b1;
        tick();
        io.finishing_fdtd = 1'b0; io.computing_on = 1'b0;
        tick();
    endtask

    task automatic vwr(input int v, input int a);
        io.Vn1 = DATA_W'(v); io.Vn1_addr = ADDR_W'(a); io.Vn1_valid = 1'b1;
        tick();
        io.Vn1_valid = 1'b0;
    endtask

    task automatic readback(input string tag, input int a, input int exp);
        io.addr = ADDR_W'(a); io.we = 1'b0;
        tick();
        chk(tag, io.out_n, DATA_W'(exp));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end
        io.pe_number = 6'd3; io.target_pe = 6'd3; io.data = '0; io.addr = '0; io.we = 1'b0;
        io.computing_on = 1'b0; io.mode = 2'd0; io.n_addr = '0; io.n_valid = 1'b0;
        io.Vn1 = '0; io.Vn1_addr = '0; io.Vn1_valid = 1'b0;
        io.starting_write = 1'b0; io.finishing_fdtd = 1'b0;

        rst = 1'b1;
        tick(); tick();
        chk("rst_out_n", io.out_n, '0);
        chk("rst_busy", DATA_W'(io.busy), '0);
        rst = 1'b0;

        // T1: load all nodes, then a foreign-target load must be ignored.
        for (int a = 0; a < DEPTH; a++) begin
            io.addr = ADDR_W'(a); io.data = DATA_W'(a * 5); io.we = 1'b1;
            tick();
        end
        readback("t1_rb7", 7, 35);
        io.target_pe = 6'd4;
        for (int a = 0; a < DEPTH; a++) begin
            io.addr = ADDR_W'(a); io.data = DATA_W'(a * 5 + 1); io.we = 1'b1;
            tick();
        end
        readback("t1_foreign7", 7, 35);
        readback("t1_foreign127", 127, 635);
        io.target_pe = 6'd3;

        // T2: copy mode; only boundary addresses capture.
        io.mode = 2'd1; io.starting_write = 1'b1;
        run_start();
        vwr(-100, 2); vwr(50, 60); vwr(9, 106);
        chk("t2_cnt", DATA_W'(io.boundary_cnt), DATA_W'(2));
        run_end();
        readback("t2_addr2", 2, -100);
        readback("t2_addr106", 106, 9);
        readback("t2_addr60", 60, 300);

        // T3: edge PE captures everywhere; damped copy.
        io.pe_number = 6'(EDGE_PE); io.mode = 2'd2;
        run_start();
        vwr(160, 60); vwr(-160, 61);
        run_end();
        readback("t3_damp_pos", 60, 150);
        readback("t3_damp_neg", 61, -150);
        io.pe_number = 6'd3;

        // T4: wrapped read with same-cycle capture to the read address.
        io.mode = 2'd1;
        run_start();
        io.n_addr = '0; io.n_valid = 1'b1;
        vwr(77, 126);
        chk("t4_wrap_valid", DATA_W'(io.out_valid), DATA_W'(1));
        chk("t4_bypass", io.out_n, DATA_W'(77));
        io.n_addr = 7'd1;
        tick();
        chk("t4_wrap127", io.out_n, DATA_W'(635));
        run_end();

        // T5: abort mid-read, then finish with a capture pending.
        run_start();
        io.n_addr = 7'd10; io.n_valid = 1'b1; io.computing_on = 1'b0;
        tick();
        chk("t5_abort_valid", DATA_W'(io.out_valid), '0);
        chk("t5_abort_busy", DATA_W'(io.busy), '0);
        io.n_valid = 1'b0;
        run_start();
        io.Vn1 = DATA_W'(55); io.Vn1_addr = 7'd3; io.Vn1_valid = 1'b1;
        io.finishing_fdtd = 1'b1; io.n_addr = 7'd12; io.n_valid = 1'b1;
        tick();
        chk("t5_drain_busy", DATA_W'(io.busy), DATA_W'(1));
        chk("t5_drain_read", io.out_n, DATA_W'(50));
        io.finishing_fdtd = 1'b0; io.computing_on = 1'b0; io.Vn1_valid = 1'b0; io.n_valid = 1'b0;
        tick();
        chk("t5_idle_busy", DATA_W'(io.busy), '0);
        readback("t5_no_write", 3, 15);

        // T6: mode 0 never writes; counter saturates.
        io.mode = 2'd0;
        run_start();
        vwr(1000, 0); vwr(1000, 1); vwr(1000, 2);
        chk("t6_mode0_cnt", DATA_W'(io.boundary_cnt), '0);
        run_end();
        readback("t6_mode0_ram", 1, 5);
        io.mode = 2'd1;
        run_start();
        for (int i = 0; i < 5; i++) vwr(i + 1, 110 + i);
        chk("t6_sat", DATA_W'(io.boundary_cnt), DATA_W'(CNT_MAX));
        run_end();

        // Randomized traffic; the model tracks run/abort/drain on its own.
        for (int blk = 0; blk < 4; blk++) begin
            io.computing_on = 1'b0; io.finishing_fdtd = 1'b0;
            tick(); tick();
            io.pe_number = (blk % 2 == 0) ? 6'd3 : 6'(EDGE_PE);
            for (int c = 0; c < 250; c++) begin
                io.computing_on   = ($urandom_range(0, 99) != 0);
                io.finishing_fdtd = ($urandom_range(0, 39) == 0);
                io.mode           = 2'($urandom_range(0, 3));
                io.starting_write = ($urandom_range(0, 3) != 0);
                io.n_addr         = ADDR_W'($urandom);
                io.n_valid        = 1'($urandom);
                io.Vn1            = DATA_W'($urandom);
                io.Vn1_addr       = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(100, 127))
                                                               : ADDR_W'($urandom);
                io.Vn1_valid      = 1'($urandom);
                io.we             = 1'($urandom);
                io.target_pe      = ($urandom_range(0, 1) == 0) ? io.pe_number : 6'd9;
                io.addr           = ADDR_W'($urandom);
                io.data           = DATA_W'($urandom);
                rst               = (blk == 2 && c == 120);
                tick();
                rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
